mem_arbiter3: RTL and testbench
===============================

MEM_ARBITER3 -- requirements
Module: mem_arbiter3

Interface
REQ-001 Parameter: WIDTH, 32, data/address width of every bus port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  3  per-requester access request; bit i belongs to requester i.
REQ-005 we  input  3  per-requester write enable (1 = write, 0 = read), sampled with req.
REQ-006 addr0, addr1, addr2  input  WIDTH  requester addresses.
REQ-007 wdata0, wdata1, wdata2  input  WIDTH  requester write data.
REQ-008 mem_ready  input  1  memory completion strobe for the current access.
REQ-009 mem_rdata  input  WIDTH  memory read data, valid when mem_ready=1.
REQ-010 mem_valid  output  1  an access is presented to memory.
REQ-011 mem_we, mem_addr, mem_wdata  output  1/WIDTH/WIDTH  selected requester's access.
REQ-012 sel  output  2  mux control: 2'b00/01/10 selects requester 0/1/2; never 2'b11.
REQ-013 gnt  output  3  one-hot grant; all zero when no grant is active.
REQ-014 done  output  3  one-cycle completion pulse to the granted requester.
REQ-015 rdata  output  WIDTH  data from the last completed read, held until the next read completes.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-017 In IDLE with req != 0, the block SHALL choose a winner round-robin, searching from (last+1) mod 3, then enter BUSY on the next edge.
REQ-018 In BUSY: gnt = onehot(winner); sel = winner; mem_valid = 1; mem_we/addr/wdata = the winner's we/addr/wdata.
REQ-019 Request-to-mem_valid latency SHALL be exactly 1 cycle.
REQ-020 The block SHALL remain in BUSY, holding winner, for as many cycles as mem_ready stays 0.
REQ-021 On mem_ready=1 in BUSY, the block SHALL enter DONE, load last := winner, and capture mem_rdata into rdata if mem_we=0.
REQ-022 In DONE: done[winner] = 1 for exactly one cycle; gnt = 0; mem_valid = 0; then return to IDLE unconditionally.
REQ-023 Requesters SHALL deassert req in the done cycle, since a req still high in IDLE competes again at lowest priority.
REQ-024 Deasserting req while BUSY SHALL NOT abort the access; the access completes normally.
REQ-025 mem_ready outside BUSY SHALL be ignored.
REQ-026 When mem_valid = 0, mem_addr, mem_wdata and mem_we SHALL be 0, and sel SHALL be 2'b00.
REQ-027 Each requester waits at most 2 other accesses between asserting req and receiving its grant, assuming finite mem_ready delay.

Reset
REQ-028 reset_n = 0 SHALL immediately force: state IDLE; gnt = 0; done = 0; mem_valid = 0; sel = 2'b00; mem_* = 0; rdata = 0; last = 2, so requester 0 has first priority.
REQ-029 A reset during BUSY SHALL abandon the access without asserting done; after release, arbitration restarts from requester 0.

Structure
REQ-030 State encodings and the sel codes SEL_R0/SEL_R1/SEL_R2 SHALL live in the shared processor-definitions package.
REQ-031 The 3-way WIDTH-bit selection SHALL be one sub-module, sel3_32b, instantiated twice (address and write data) and driven by sel.
REQ-032 sel3_32b SHALL output 0 for sel = 2'b11.

Verification
REQ-033 Single read: req=3'b010, addr1=0x10, mem_ready after 2 cycles with mem_rdata=0xCAFEF00D -> mem_valid 1 cycle after req, sel=01, mem_addr=0x10; done=010 for one cycle; rdata=0xCAFEF00D.
REQ-034 Round-robin: req=3'b111 held for three accesses, mem_ready immediate -> grant order 0, 1, 2, with gnt one-hot throughout.
REQ-035 Write: req=3'b100, we=3'b100, wdata2=0x55555555, addr2=0xFFFF0000 -> mem_we=1, sel=10, mem_wdata=0x55555555; rdata unchanged.
REQ-036 Stall: mem_ready=0 for 10 cycles while req=3'b011 -> gnt, sel and mem_addr stable all 10 cycles; requester 1 granted only after requester 0's done.
REQ-037 Reset mid-BUSY: reset_n=0 during a requester-1 access -> all outputs 0 immediately with no done pulse; after release, req=3'b011 grants requester 0 first.
REQ-038 Assertions: sel != 2'b11; $onehot0(gnt); done never coincides with mem_valid.

Source files
------------

// File: rtl/mem_arbiter3_pkg.sv
// Shared definitions for the three-requester memory arbiter: FSM state codes,
// mux select codes and the round-robin winner search.
package mem_arbiter3_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SEL_R0 = 2'b00;
    localparam logic [1:0] SEL_R1 = 2'b01;
    localparam logic [1:0] SEL_R2 = 2'b10;

    // Walk candidates from farthest to nearest so the nearest requester after
    // 'last' is the one left in pick.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] pick;
        int idx;
        pick = SEL_R0;
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(last) + k) % 3;
            if (req[idx]) pick = 2'(idx);
        end
        return pick;
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] s);
        return 3'b001 << s;
    endfunction

endpackage

// File: rtl/sel3_32b.sv
// Three-way WIDTH-bit selector; the unused select code yields zero.
module sel3_32b #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        case (sel)
            2'b00:   out = in0;
            2'b01:   out = in1;
            2'b10:   out = in2;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter3.sv
// Round-robin arbiter giving three requesters one-at-a-time access to a single
// memory port through an IDLE -> BUSY -> DONE handshake.
module mem_arbiter3
    import mem_arbiter3_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       req,
    input  logic [2:0]       we,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] addr2,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [WIDTH-1:0] wdata2,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_valid,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [1:0]       sel,
    output logic [2:0]       gnt,
    output logic [2:0]       done,
    output logic [WIDTH-1:0] rdata
);

    logic [1:0]       state;
    logic [1:0]       winner;
    logic [1:0]       last;
    logic             we_q;
    logic [1:0]       pick;
    logic             busy;
    logic [WIDTH-1:0] addr_mux;
    logic [WIDTH-1:0] wdata_mux;

    assign pick = rr_pick(req, last);

    // The write enable is latched at grant; address and data follow the winner live.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            winner <= SEL_R0;
            last   <= SEL_R2;
            we_q   <= 1'b0;
            rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        winner <= pick;
                        we_q   <= we[pick];
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        state <= ST_DONE;
                        last  <= winner;
                        if (!we_q) rdata <= mem_rdata;
                    end
                end
                ST_DONE: state   <= ST_IDLE;
                default: state   <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_BUSY);
    assign mem_valid = busy;
    assign sel       = busy ? winner : SEL_R0;
    assign gnt       = busy ? onehot3(winner) : 3'b000;
    assign done      = (state == ST_DONE) ? onehot3(winner) : 3'b000;
    assign mem_we    = busy & we_q;
    assign mem_addr  = busy ? addr_mux : '0;
    assign mem_wdata = busy ? wdata_mux : '0;

    sel3_32b #(.WIDTH(WIDTH)) u_addr_sel (
        .in0 (addr0),
        .in1 (addr1),
        .in2 (addr2),
        .sel (sel),
        .out (addr_mux)
    );

    sel3_32b #(.WIDTH(WIDTH)) u_wdata_sel (
        .in0 (wdata0),
        .in1 (wdata1),
        .in2 (wdata2),
        .sel (sel),
        .out (wdata_mux)
    );

endmodule

// File: tb/tb_mem_arbiter3.sv
// Self-checking bench for mem_arbiter3: directed table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_mem_arbiter3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [31:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [1:0]  sel;
    logic [2:0]  gnt, done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_arbiter3 #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .sel(sel), .gnt(gnt), .done(done), .rdata(rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Structural invariants sampled every cycle outside reset.
    always @(negedge clk) begin
        if (reset_n) begin
            check("inv_sel_not_11", 32'(sel == 2'b11), 32'd0);
            check("inv_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("inv_done_vs_valid", 32'((done != 3'b000) && mem_valid), 32'd0);
        end
    end

    function automatic int rr_model(input logic [2:0] r, input int last_idx);
        for (int k = 1; k <= 3; k++)
            if (r[(last_idx + k) % 3]) return (last_idx + k) % 3;
        return -1;
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        req       = '0;
        we        = '0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One complete access; entered and left at a negedge with the DUT idle.
    task automatic do_access(input logic [2:0] r, input logic [2:0] w, input int stall,
                             input logic [31:0] rd, input int exp_win,
                             input logic [31:0] exp_rdata, input bit drop,
                             input bit noise, input string tag);
        logic [2:0]  oh;
        logic [31:0] ea, ed;
        oh = 3'b001 << exp_win;
        ea = (exp_win == 0) ? addr0 : (exp_win == 1) ? addr1 : addr2;
        ed = (exp_win == 0) ? wdata0 : (exp_win == 1) ? wdata1 : wdata2;
        if (noise) begin
            req       = '0;
            mem_ready = 1'b1;
            mem_rdata = 32'hBAD0BAD0;
            @(posedge clk); @(negedge clk);
            check({tag, "_noise_valid"}, 32'(mem_valid), 32'd0);
            check({tag, "_noise_done"}, 32'(done), 32'd0);
            mem_ready = 1'b0;
        end
        req = r;
        we  = w;
        check({tag, "_idle_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_idle_addr"}, mem_addr, 32'd0);
        check({tag, "_idle_sel"}, 32'(sel), 32'd0);
        @(posedge clk); @(negedge clk);
        check({tag, "_gnt"}, 32'(gnt), 32'(oh));
        check({tag, "_sel"}, 32'(sel), 32'(exp_win));
        check({tag, "_valid"}, 32'(mem_valid), 32'd1);
        check({tag, "_addr"}, mem_addr, ea);
        check({tag, "_wdata"}, mem_wdata, ed);
        check({tag, "_we"}, 32'(mem_we), 32'(w[exp_win]));
        check({tag, "_busy_done"}, 32'(done), 32'd0);
        if (drop) req = '0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); @(negedge clk);
            check({tag, "_stall_gnt"}, 32'(gnt), 32'(oh));
            check({tag, "_stall_sel"}, 32'(sel), 32'(exp_win));
            check({tag, "_stall_addr"}, mem_addr, ea);
            check({tag, "_stall_done"}, 32'(done), 32'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0;
        check({tag, "_done"}, 32'(done), 32'(oh));
        check({tag, "_done_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_done_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_done_addr"}, mem_addr, 32'd0);
        check({tag, "_done_wdata"}, mem_wdata, 32'd0);
        check({tag, "_done_we"}, 32'(mem_we), 32'd0);
        check({tag, "_done_sel"}, 32'(sel), 32'd0);
        req = '0;
        @(posedge clk); @(negedge clk);
        check({tag, "_post_done"}, 32'(done), 32'd0);
        check({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        int          stall;
        logic [31:0] rd;
        int          exp_win;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int          last_m;
        logic [31:0] rdata_m;
        logic [2:0]  r, w;
        int          win;
        logic [31:0] rd;

        tbl[0] = '{3'b010, 3'b000, 2,  32'hCAFEF00D, 1, 32'hCAFEF00D};
        tbl[1] = '{3'b111, 3'b000, 0,  32'h11111111, 2, 32'h11111111};
        tbl[2] = '{3'b111, 3'b000, 0,  32'h22222222, 0, 32'h22222222};
        tbl[3] = '{3'b111, 3'b111, 1,  32'h33333333, 1, 32'h22222222};
        tbl[4] = '{3'b100, 3'b100, 0,  32'hDEADBEEF, 2, 32'h22222222};
        tbl[5] = '{3'b011, 3'b000, 10, 32'h44444444, 0, 32'h44444444};
        tbl[6] = '{3'b011, 3'b000, 0,  32'h55555555, 1, 32'h55555555};
        tbl[7] = '{3'b101, 3'b001, 3,  32'h66666666, 2, 32'h66666666};
        tbl[8] = '{3'b101, 3'b001, 0,  32'h77777777, 0, 32'h66666666};

        addr0 = 32'h00000A00; addr1 = 32'h00000010; addr2 = 32'hFFFF0000;
        wdata0 = 32'h0A0A0A0A; wdata1 = 32'h11111111; wdata2 = 32'h55555555;

        // Reset state
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(mem_valid), 32'd0);
        do_reset();
        check("rst_done", 32'(done), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_rdata", rdata, 32'd0);

        foreach (tbl[i])
            do_access(tbl[i].req, tbl[i].we, tbl[i].stall, tbl[i].rd, tbl[i].exp_win,
                      tbl[i].exp_rdata, 1'b0, 1'b0, $sformatf("tbl%0d", i));

        // Round-robin with all requests held and immediate completion
        do_reset();
        req       = 3'b111;
        we        = 3'b000;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(3'b001 << k));
            @(posedge clk); @(negedge clk);
            check($sformatf("rr%0d_done", k), 32'(done), 32'(3'b001 << k));
            @(posedge clk); @(negedge clk);
            check($sformatf("rr%0d_idle_gnt", k), 32'(gnt), 32'd0);
        end
        req       = '0;
        mem_ready = 1'b0;
        @(negedge clk);

        // Reset in the middle of a requester-1 access
        do_reset();
        req = 3'b010;
        @(posedge clk); @(negedge clk);
        check("mid_gnt_before", 32'(gnt), 32'b010);
        #2 reset_n = 1'b0;
        #1;
        check("mid_gnt", 32'(gnt), 32'd0);
        check("mid_valid", 32'(mem_valid), 32'd0);
        check("mid_sel", 32'(sel), 32'd0);
        check("mid_addr", mem_addr, 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_rdata", rdata, 32'd0);
        req = '0;
        repeat (2) begin
            @(negedge clk);
            check("mid_hold_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        req     = 3'b011;
        @(posedge clk); @(negedge clk);
        check("mid_regrant", 32'(gnt), 32'b001);
        mem_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0;
        req       = '0;
        check("mid_regrant_done", 32'(done), 32'b001);
        @(negedge clk);

        // Randomized transactions against the transaction-level model
        do_reset();
        last_m  = 2;
        rdata_m = '0;
        for (int n = 0; n < 150; n++) begin
            r      = 3'($urandom_range(1, 7));
            w      = 3'($urandom);
            rd     = $urandom;
            addr0  = $urandom; addr1  = $urandom; addr2  = $urandom;
            wdata0 = $urandom; wdata1 = $urandom; wdata2 = $urandom;
            win    = rr_model(r, last_m);
            if (!w[win]) rdata_m = rd;
            last_m = win;
            do_access(r, w, int'($urandom_range(0, 4)), rd, win, rdata_m,
                      ($urandom % 4) == 0, ($urandom % 4) == 0, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
